// File: rtl/bcd_cascade_counter_if.sv
// Bus bundle for the cascaded BCD counter: control inputs plus registered status.
interface bcd_cascade_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic                  counter_on;
  logic                  counter_up;
  logic                  saturate;
  logic [4*DIGITS-1:0]   count;
  logic [DIGITS-1:0]     digit_tc;
  logic                  tc;
  logic                  load_err;

  modport master (
    output load, data_in, counter_on, counter_up, saturate,
    input  count, digit_tc, tc, load_err
  );

  modport slave (
    input  load, data_in, counter_on, counter_up, saturate,
    output count, digit_tc, tc, load_err
  );
endinterface

// File: rtl/bcd_cascade_counter.sv
// Cascaded BCD up/down counter with parallel load, optional saturation and
// a terminal-count flag that is either a single-cycle pulse or stretched.
module bcd_cascade_counter #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned TC_STRETCH = 0
) (
  input logic                   clock,
  input logic                   reset,
  bcd_cascade_counter_if.slave  bus
);

  logic [4*DIGITS-1:0] count_q;
  logic                tc_q;
  logic                load_err_q;

  logic [4*DIGITS-1:0] next_cnt;
  logic [4*DIGITS-1:0] load_val;
  logic                load_bad;
  logic                wrap;
  logic [DIGITS-1:0]   dtc;

  // Clamp the load value per nibble and note whether any nibble was illegal.
  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.data_in[4*i +: 4] > 4'd9) begin
        load_val[4*i +: 4] = 4'd9;
        load_bad           = 1'b1;
      end else begin
        load_val[4*i +: 4] = bus.data_in[4*i +: 4];
      end
    end
  end

  // Ripple the carry/borrow through the decades; a carry out of the top digit is the wrap event.
  always_comb begin
    logic carry;
    carry    = 1'b1;
    next_cnt = count_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.counter_up) begin
        if (carry) begin
          next_cnt[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
        end
        carry = carry & (count_q[4*i +: 4] == 4'd9);
      end else begin
        if (carry) begin
          next_cnt[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
        end
        carry = carry & (count_q[4*i +: 4] == 4'd0);
      end
    end
    wrap = carry;
  end

  // Per-digit terminal flags from the registered count, suppressed while loading.
  always_comb begin
    dtc = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dtc[i] = bus.counter_on & ~bus.load &
               (( bus.counter_up & (count_q[4*i +: 4] == 4'd9)) |
                (~bus.counter_up & (count_q[4*i +: 4] == 4'd0)));
    end
  end

  // Count/load register with terminal-count and load-error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.load) begin
      count_q    <= load_val;
      load_err_q <= load_bad;
      tc_q       <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      if (bus.counter_on) begin
        // Saturation just suppresses the rollover; tc still marks the wrap attempt.
        if (!(wrap && bus.saturate)) begin
          count_q <= next_cnt;
        end
        tc_q <= wrap;
      end else if (TC_STRETCH == 0) begin
        tc_q <= 1'b0;
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.digit_tc = dtc;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: two DIGITS=2 instances (pulse and stretched tc)
// share one stimulus stream and are compared each cycle with an integer-valued model.
module tb_bcd_cascade_counter;
  localparam int D    = 2;
  localparam int MAXV = (10**D) - 1;

  logic clock;
  logic reset;
  logic         load;
  logic [4*D-1:0] data_in;
  logic         counter_on, counter_up, saturate;
  bit           chk_en;

  int n_checks = 0;
  int n_errors = 0;

  bcd_cascade_counter_if #(.DIGITS(D)) bus0 ();
  bcd_cascade_counter_if #(.DIGITS(D)) bus1 ();

  assign bus0.load = load;       assign bus1.load = load;
  assign bus0.data_in = data_in; assign bus1.data_in = data_in;
  assign bus0.counter_on = counter_on; assign bus1.counter_on = counter_on;
  assign bus0.counter_up = counter_up; assign bus1.counter_up = counter_up;
  assign bus0.saturate = saturate;     assign bus1.saturate = saturate;

  bcd_cascade_counter #(.DIGITS(D), .TC_STRETCH(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  bcd_cascade_counter #(.DIGITS(D), .TC_STRETCH(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: the count is a plain integer 0..MAXV.
  int m_val;
  bit m_tc0, m_tc1, m_lerr;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int p;
    r = '0;
    p = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] exp_dtc(input int v, input logic on, input logic up, input logic ld);
    logic [D-1:0] r;
    int p, dg;
    r = '0;
    p = v;
    for (int i = 0; i < D; i++) begin
      dg = p % 10;
      p = p / 10;
      r[i] = on && !ld && ((up && dg == 9) || (!up && dg == 0));
    end
    return r;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_val = 0; m_tc0 = 0; m_tc1 = 0; m_lerr = 0;
    end else if (load) begin
      int v, nib;
      bit bad;
      v = 0; bad = 0;
      for (int i = D-1; i >= 0; i--) begin
        nib = int'(data_in[4*i +: 4]);
        if (nib > 9) begin nib = 9; bad = 1; end
        v = v*10 + nib;
      end
      m_val = v; m_lerr = bad; m_tc0 = 0; m_tc1 = 0;
    end else begin
      m_lerr = 0;
      if (counter_on) begin
        bit w;
        w = counter_up ? (m_val == MAXV) : (m_val == 0);
        if (w) begin
          if (!saturate) m_val = counter_up ? 0 : MAXV;
        end else begin
          m_val = counter_up ? m_val + 1 : m_val - 1;
        end
        m_tc0 = w; m_tc1 = w;
      end else begin
        m_tc0 = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("count0",    32'(bus0.count),    32'(to_bcd(m_val)));
      check("count1",    32'(bus1.count),    32'(to_bcd(m_val)));
      check("digit_tc0", 32'(bus0.digit_tc), 32'(exp_dtc(m_val, counter_on, counter_up, load)));
      check("digit_tc1", 32'(bus1.digit_tc), 32'(exp_dtc(m_val, counter_on, counter_up, load)));
      check("tc0",       32'(bus0.tc),       32'(m_tc0));
      check("tc1",       32'(bus1.tc),       32'(m_tc1));
      check("load_err0", 32'(bus0.load_err), 32'(m_lerr));
      check("load_err1", 32'(bus1.load_err), 32'(m_lerr));
    end
  end

  task automatic drive(input logic ld, input logic [4*D-1:0] d, input logic on,
                       input logic up, input logic sat);
    load = ld; data_in = d; counter_on = on; counter_up = up; saturate = sat;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, 0, 1, 0);
    #1 reset = 1'b0;
    #1;
    check("rst_count", 32'(bus0.count), 32'h0);
    check("rst_tc",    32'(bus0.tc), 32'h0);
    check("rst_lerr",  32'(bus1.load_err), 32'h0);
    chk_en = 1'b1;
    tick(2);
    reset = 1'b1;

    // Free-running up count through a full cycle.
    drive(0, '0, 1, 1, 0);
    tick(99);
    check("up99_count", 32'(bus0.count), 32'h99);
    check("up99_tc",    32'(bus0.tc), 32'h0);
    check("up99_dtc",   32'(bus0.digit_tc), 32'h3);
    tick(1);
    check("wrap_count", 32'(bus0.count), 32'h00);
    check("wrap_tc0",   32'(bus0.tc), 32'h1);
    check("model_pin_wrap", 32'(to_bcd(m_val)), 32'h00);
    tick(1);
    check("after_wrap_tc0", 32'(bus0.tc), 32'h0);
    check("after_wrap_tc1", 32'(bus1.tc), 32'h0);
    check("after_wrap_cnt", 32'(bus0.count), 32'h01);

    // Down from zero: rollover, then saturation.
    drive(1, 8'h00, 0, 0, 0); tick(1);
    drive(0, 8'h00, 1, 0, 0); tick(1);
    check("down_roll_count", 32'(bus0.count), 32'h99);
    check("down_roll_tc",    32'(bus0.tc), 32'h1);
    drive(1, 8'h00, 0, 0, 1); tick(1);
    drive(0, 8'h00, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("sat_count", 32'(bus0.count), 32'h00);
      check("sat_tc",    32'(bus0.tc), 32'h1);
    end

    // Illegal nibble clamp and load_err.
    drive(1, 8'h3C, 0, 1, 0); tick(1);
    check("clamp_count", 32'(bus0.count), 32'h39);
    check("clamp_lerr",  32'(bus0.load_err), 32'h1);
    check("model_pin_clamp", 32'(to_bcd(m_val)), 32'h39);
    drive(0, 8'h00, 0, 1, 0); tick(1);
    check("lerr_clear", 32'(bus0.load_err), 32'h0);
    drive(1, 8'h12, 0, 1, 0); tick(1);
    check("legal_lerr",  32'(bus0.load_err), 32'h0);
    check("legal_count", 32'(bus0.count), 32'h12);

    // Decade carry and direction change.
    drive(1, 8'h19, 0, 1, 0); tick(1);
    drive(0, 8'h00, 1, 1, 0); #1;
    check("dtc_19_up", 32'(bus0.digit_tc), 32'h1);
    tick(1);
    check("carry_count", 32'(bus0.count), 32'h20);
    check("dtc_20_up",   32'(bus0.digit_tc), 32'h0);
    counter_up = 1'b0; #1;
    check("dtc_20_dn",   32'(bus0.digit_tc), 32'h1);
    tick(1);
    check("borrow_count", 32'(bus0.count), 32'h19);
    check("dtc_19_dn",    32'(bus0.digit_tc), 32'h0);

    // Load wins over count; asynchronous reset between edges.
    drive(1, 8'h55, 1, 1, 0); tick(1);
    check("ld_pri_count", 32'(bus0.count), 32'h55);
    check("ld_pri_tc",    32'(bus0.tc), 32'h0);
    drive(0, 8'h00, 1, 1, 0); tick(1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", 32'(bus0.count), 32'h00);
    check("async_rst_tc1",   32'(bus1.tc), 32'h0);
    @(negedge clock); #2 reset = 1'b1;
    tick(1);
    check("post_rst_count", 32'(bus0.count), 32'h01);

    // Stretched tc across idle cycles.
    drive(1, 8'h98, 0, 1, 0); tick(1);
    drive(0, 8'h00, 1, 1, 0); tick(2);
    check("str_wrap_tc1", 32'(bus1.tc), 32'h1);
    counter_on = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("str_hold_tc1", 32'(bus1.tc), 32'h1);
      check("str_hold_tc0", 32'(bus0.tc), 32'h0);
    end
    counter_on = 1'b1; tick(1);
    check("str_drop_tc1", 32'(bus1.tc), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 59) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      tick(1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
